// File: rtl/a2d_arb_pkg.sv
// Shared types and widths for the A2D arbiter.
package a2d_arb_pkg;
  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} arb_state_t;
  typedef enum logic {OWN_MC = 1'b0, OWN_HK = 1'b1} owner_t;
  localparam int A2D_RES_W = 12;
  localparam int A2D_CHN_W = 3;
endpackage

// File: rtl/a2d_arb_if.sv
// Requester and A2D front-end signals of the arbiter; slave is the arbiter side.
interface a2d_arb_if;
  import a2d_arb_pkg::*;

  logic                 req0;
  logic [A2D_CHN_W-1:0] chnnl0;
  logic                 req1;
  logic [A2D_CHN_W-1:0] chnnl1;
  logic                 a2d_cnv_cmplt;
  logic [A2D_RES_W-1:0] a2d_res;
  logic                 a2d_strt_cnv;
  logic [A2D_CHN_W-1:0] a2d_chnnl;
  logic                 cmplt0;
  logic                 cmplt1;
  logic [A2D_RES_W-1:0] res;
  logic                 err;
  logic                 busy;

  modport slave (
    input  req0, chnnl0, req1, chnnl1, a2d_cnv_cmplt, a2d_res,
    output a2d_strt_cnv, a2d_chnnl, cmplt0, cmplt1, res, err, busy
  );

  modport master (
    output req0, chnnl0, req1, chnnl1, a2d_cnv_cmplt, a2d_res,
    input  a2d_strt_cnv, a2d_chnnl, cmplt0, cmplt1, res, err, busy
  );
endinterface

// File: rtl/a2d_arb_tmo_tmr.sv
// Conversion watchdog: counts enabled cycles from a clear and flags the last allowed one.
module a2d_tmo_tmr #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_reg <= '0;
    end else if (clr) begin
      tmr_reg <= '0;
    end else if (en) begin
      tmr_reg <= tmr_reg + TW'(1);
    end
  end

  assign expired = en && (tmr_reg == TW'(TIMEOUT - 1));
endmodule

// File: rtl/a2d_arb.sv
// Two-port arbiter in front of the shared A2D converter: port 0 has priority,
// port 1 is forced after STARVE_MAX consecutive port-0 grants; hung conversions time out.
module a2d_arb
  import a2d_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 4096
) (
  input logic       clk,
  input logic       rst,
  a2d_arb_if.slave  bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t           state_reg;
  owner_t               owner_reg;
  logic                 pend0_reg, pend1_reg;
  logic [A2D_CHN_W-1:0] pchn0_reg, pchn1_reg;
  logic [SW-1:0]        skip_reg;
  logic                 strt_reg, cmplt0_reg, cmplt1_reg, err_reg, busy_reg;
  logic [A2D_CHN_W-1:0] chnnl_reg;
  logic [A2D_RES_W-1:0] res_reg;

  logic starved, win_hk, grant, in_conv, tmo_expired;

  assign in_conv = (state_reg == CONV);
  assign starved = (skip_reg == SW'(STARVE_MAX));
  assign win_hk  = pend1_reg && (!pend0_reg || starved);
  assign grant   = (state_reg == IDLE) && (pend0_reg || pend1_reg);

  a2d_tmo_tmr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant),
    .en      (in_conv),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      owner_reg  <= OWN_MC;
      pend0_reg  <= 1'b0;
      pend1_reg  <= 1'b0;
      pchn0_reg  <= '0;
      pchn1_reg  <= '0;
      skip_reg   <= '0;
      strt_reg   <= 1'b0;
      cmplt0_reg <= 1'b0;
      cmplt1_reg <= 1'b0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      chnnl_reg  <= '0;
      res_reg    <= '0;
    end else begin
      strt_reg   <= 1'b0;
      cmplt0_reg <= 1'b0;
      cmplt1_reg <= 1'b0;
      err_reg    <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (grant) begin
            strt_reg  <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= CONV;
            if (win_hk) begin
              owner_reg <= OWN_HK;
              chnnl_reg <= pchn1_reg;
              pend1_reg <= 1'b0;
              skip_reg  <= '0;
            end else begin
              owner_reg <= OWN_MC;
              chnnl_reg <= pchn0_reg;
              pend0_reg <= 1'b0;
              if (pend1_reg && !starved) begin
                skip_reg <= skip_reg + SW'(1);
              end
            end
          end
        end
        CONV: begin
          // A real completion beats a timeout landing on the same edge.
          if (bus.a2d_cnv_cmplt || tmo_expired) begin
            res_reg    <= bus.a2d_cnv_cmplt ? bus.a2d_res : '0;
            err_reg    <= !bus.a2d_cnv_cmplt;
            cmplt0_reg <= (owner_reg == OWN_MC);
            cmplt1_reg <= (owner_reg == OWN_HK);
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end
        end
      endcase

      // Placed after the grant so a same-edge request re-arms the pend.
      if (bus.req0) begin
        pend0_reg <= 1'b1;
        pchn0_reg <= bus.chnnl0;
      end
      if (bus.req1) begin
        pend1_reg <= 1'b1;
        pchn1_reg <= bus.chnnl1;
      end
    end
  end

  assign bus.a2d_strt_cnv = strt_reg;
  assign bus.a2d_chnnl    = chnnl_reg;
  assign bus.cmplt0       = cmplt0_reg;
  assign bus.cmplt1       = cmplt1_reg;
  assign bus.res          = res_reg;
  assign bus.err          = err_reg;
  assign bus.busy         = busy_reg;
endmodule

// File: tb/tb_a2d_arb.sv
// Self-checking bench for a2d_arb: cycle vectors, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_a2d_arb;
  import a2d_arb_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  a2d_arb_if bus();

  a2d_arb #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct { int t; logic [2:0] ch; } strt_ev_t;
  typedef struct { int t; logic port; logic [11:0] res; logic err; } done_ev_t;
  strt_ev_t strt_q[$];
  done_ev_t done_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.a2d_strt_cnv) strt_q.push_back('{cyc_n, bus.a2d_chnnl});
      if (bus.cmplt0 || bus.cmplt1) done_q.push_back('{cyc_n, bus.cmplt1, bus.res, bus.err});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // {strt_cnv, chnnl, cmplt0, cmplt1, res, err, busy}
  function automatic logic [19:0] outs();
    return {bus.a2d_strt_cnv, bus.a2d_chnnl, bus.cmplt0, bus.cmplt1, bus.res, bus.err, bus.busy};
  endfunction

  function automatic logic [19:0] ov(input logic s, input logic [2:0] ch, input logic d0,
                                     input logic d1, input logic [11:0] r, input logic e,
                                     input logic b);
    return {s, ch, d0, d1, r, e, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.chnnl0 = '0; bus.req1 = 1'b0; bus.chnnl1 = '0;
    bus.a2d_cnv_cmplt = 1'b0; bus.a2d_res = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("reset_outs", 32'(outs()), 32'h0);
    rst = 1'b0;
    step();
    strt_q.delete();
    done_q.delete();
  endtask

  task automatic pulse(input int p, input logic [2:0] ch);
    if (p == 0) begin bus.req0 = 1'b1; bus.chnnl0 = ch; end
    else        begin bus.req1 = 1'b1; bus.chnnl1 = ch; end
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic complete(input logic [11:0] r);
    bus.a2d_cnv_cmplt = 1'b1;
    bus.a2d_res = r;
    step();
    bus.a2d_cnv_cmplt = 1'b0;
    bus.a2d_res = '0;
  endtask

  task automatic wait_strt(input string name, input int limit);
    int w = 0;
    while (bus.a2d_strt_cnv !== 1'b1 && w < limit) begin
      step();
      w++;
    end
    if (w >= limit) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: a2d_strt_cnv got 0 for %0d cycles, required 1", name, limit);
    end
  endtask

  // Reference model: pending requests, starvation count and conversion age as plain integers.
  bit          m_pend[2];
  logic [2:0]  m_pch[2];
  int          m_skip, m_own, m_age, m_dly;
  bit          m_conv;
  logic        m_strt, m_d0, m_d1, m_err;
  logic [2:0]  m_chn;
  logic [11:0] m_res;

  task automatic model_init();
    m_pend = '{0, 0}; m_pch[0] = '0; m_pch[1] = '0;
    m_skip = 0; m_own = 0; m_age = 0; m_dly = 0; m_conv = 0;
    m_strt = 0; m_d0 = 0; m_d1 = 0; m_err = 0; m_chn = '0; m_res = '0;
  endtask

  task automatic model_step();
    int w;
    m_strt = 0; m_d0 = 0; m_d1 = 0; m_err = 0;
    if (m_conv) begin
      m_age++;
      if (bus.a2d_cnv_cmplt || m_age == TIMEOUT) begin
        m_res  = bus.a2d_cnv_cmplt ? bus.a2d_res : 12'h000;
        m_err  = !bus.a2d_cnv_cmplt;
        m_d0   = (m_own == 0);
        m_d1   = (m_own == 1);
        m_conv = 0;
      end
    end else if (m_pend[0] || m_pend[1]) begin
      w = (m_pend[1] && (!m_pend[0] || m_skip == STARVE_MAX)) ? 1 : 0;
      if (w == 1) m_skip = 0;
      else if (m_pend[1]) m_skip = (m_skip + 1 > STARVE_MAX) ? STARVE_MAX : m_skip + 1;
      m_strt = 1; m_chn = m_pch[w]; m_own = w; m_pend[w] = 0;
      m_age = 0; m_conv = 1; m_dly = $urandom_range(0, 10);
    end
    if (bus.req0) begin m_pend[0] = 1; m_pch[0] = bus.chnnl0; end
    if (bus.req1) begin m_pend[1] = 1; m_pch[1] = bus.chnnl1; end
  endtask

  typedef struct {
    logic r0; logic [2:0] c0; logic r1; logic [2:0] c1;
    logic cc; logic [11:0] rv; logic [19:0] exp;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, bad;
    logic [11:0] exp_port;

    idle_inputs();
    do_reset();

    // Simultaneous requests, back-to-back conversions, then a stray completion in IDLE.
    vecs[0] = '{1'b1, 3'd1, 1'b1, 3'd6, 1'b0, 12'h000, ov(0, 3'd0, 0, 0, 12'h000, 0, 0)};
    vecs[1] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 12'h000, ov(0, 3'd0, 0, 0, 12'h000, 0, 0)};
    vecs[2] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 12'h000, ov(1, 3'd1, 0, 0, 12'h000, 0, 1)};
    vecs[3] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 12'h123, ov(0, 3'd1, 0, 0, 12'h000, 0, 1)};
    vecs[4] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 12'h000, ov(0, 3'd1, 1, 0, 12'h123, 0, 0)};
    vecs[5] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 12'h000, ov(1, 3'd6, 0, 0, 12'h123, 0, 1)};
    vecs[6] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 12'hFED, ov(0, 3'd6, 0, 0, 12'h123, 0, 1)};
    vecs[7] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 12'h000, ov(0, 3'd6, 0, 1, 12'hFED, 0, 0)};
    vecs[8] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 12'h777, ov(0, 3'd6, 0, 0, 12'hFED, 0, 0)};
    vecs[9] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 12'h000, ov(0, 3'd6, 0, 0, 12'hFED, 0, 0)};
    foreach (vecs[i]) begin
      bus.req0 = vecs[i].r0; bus.chnnl0 = vecs[i].c0;
      bus.req1 = vecs[i].r1; bus.chnnl1 = vecs[i].c1;
      bus.a2d_cnv_cmplt = vecs[i].cc; bus.a2d_res = vecs[i].rv;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      step();
    end
    idle_inputs();

    // Single request: req0 at cycle 10, completion at cycle 40.
    do_reset();
    base = cyc_n;
    bad = 0;
    repeat (10) step();
    pulse(0, 3'd3);
    for (int t = 11; t < 40; t++) begin
      if (t >= 12 && bus.a2d_chnnl !== 3'd3) bad++;
      step();
    end
    complete(12'hA5C);
    repeat (5) step();
    check("single_strt_cnt", 32'(strt_q.size()), 32'd1);
    check("single_chnnl_held", 32'(bad), 32'd0);
    check("single_done_cnt", 32'(done_q.size()), 32'd1);
    if (strt_q.size() >= 1) begin
      check("single_strt_cycle", 32'(strt_q[0].t - base), 32'd12);
      check("single_strt_chnnl", 32'(strt_q[0].ch), 32'd3);
    end
    if (done_q.size() >= 1) begin
      check("single_done_cycle", 32'(done_q[0].t - base), 32'd41);
      check("single_done_port", 32'(done_q[0].port), 32'd0);
      check("single_res", 32'(done_q[0].res), 32'hA5C);
      check("single_err", 32'(done_q[0].err), 32'd0);
    end

    // Starvation: port 1 forced after STARVE_MAX port-0 grants, twice.
    do_reset();
    bus.req0 = 1'b1; bus.chnnl0 = 3'd0; bus.req1 = 1'b1; bus.chnnl1 = 3'd4;
    step();
    idle_inputs();
    for (int k = 0; k < 12; k++) begin
      wait_strt("starve_strt", 20);
      if (k < 11) begin bus.req0 = 1'b1; bus.chnnl0 = k[2:0]; end
      if (k == 5) begin bus.req1 = 1'b1; bus.chnnl1 = 3'd4; end
      step();
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      step();
      complete(12'h100 + 12'(k));
    end
    repeat (4) step();
    exp_port = 12'h410;
    check("starve_done_cnt", 32'(done_q.size()), 32'd12);
    for (int k = 0; k < 12; k++) begin
      if (done_q.size() > k) check($sformatf("starve_port%0d", k), 32'(done_q[k].port), 32'(exp_port[k]));
    end
    if (strt_q.size() >= 11) begin
      check("starve_hk_chnnl_a", 32'(strt_q[4].ch), 32'd4);
      check("starve_hk_chnnl_b", 32'(strt_q[10].ch), 32'd4);
    end

    // Timeout on port 1, preceded by a normal conversion so res is non-zero.
    do_reset();
    pulse(1, 3'd1);
    wait_strt("pre_strt", 10);
    step();
    complete(12'hBEE);
    step();
    strt_q.delete(); done_q.delete();
    pulse(1, 3'd5);
    wait_strt("tmo_strt", 10);
    repeat (TIMEOUT + 5) step();
    check("tmo_done_cnt", 32'(done_q.size()), 32'd1);
    if (done_q.size() >= 1 && strt_q.size() >= 1) begin
      check("tmo_chnnl", 32'(strt_q[0].ch), 32'd5);
      check("tmo_latency", 32'(done_q[0].t - strt_q[0].t), 32'(TIMEOUT));
      check("tmo_port", 32'(done_q[0].port), 32'd1);
      check("tmo_err", 32'(done_q[0].err), 32'd1);
      check("tmo_res", 32'(done_q[0].res), 32'd0);
    end
    strt_q.delete(); done_q.delete();
    pulse(0, 3'd2);
    wait_strt("post_tmo_strt", 10);
    step();
    complete(12'h3C3);
    step();
    check("post_tmo_done_cnt", 32'(done_q.size()), 32'd1);
    if (done_q.size() >= 1) begin
      check("post_tmo_res_err", 32'({done_q[0].port, done_q[0].err, done_q[0].res}), 32'h03C3);
    end

    // Completion landing exactly on the final timeout cycle wins.
    strt_q.delete(); done_q.delete();
    pulse(0, 3'd3);
    wait_strt("coinc_strt", 10);
    repeat (TIMEOUT - 1) step();
    complete(12'h5A5);
    step();
    check("coinc_done_cnt", 32'(done_q.size()), 32'd1);
    if (done_q.size() >= 1 && strt_q.size() >= 1) begin
      check("coinc_latency", 32'(done_q[0].t - strt_q[0].t), 32'(TIMEOUT));
      check("coinc_err", 32'(done_q[0].err), 32'd0);
      check("coinc_res", 32'(done_q[0].res), 32'h5A5);
    end

    // Repeat req1 during CONV: latest channel wins, single conversion.
    strt_q.delete(); done_q.delete();
    pulse(0, 3'd1);
    wait_strt("ovw_strt0", 10);
    pulse(1, 3'd2);
    pulse(1, 3'd7);
    complete(12'h111);
    wait_strt("ovw_strt1", 10);
    step();
    complete(12'h222);
    repeat (15) step();
    check("ovw_strt_cnt", 32'(strt_q.size()), 32'd2);
    check("ovw_done_cnt", 32'(done_q.size()), 32'd2);
    if (strt_q.size() >= 2) check("ovw_chnnl", 32'(strt_q[1].ch), 32'd7);
    if (done_q.size() >= 2) check("ovw_port", 32'(done_q[1].port), 32'd1);

    // Asynchronous reset mid-conversion with port 1 pending.
    pulse(0, 3'd5);
    wait_strt("rstmid_strt", 10);
    pulse(1, 3'd6);
    check("rstmid_busy_before", 32'(bus.busy), 32'd1);
    #3;
    rst = 1'b1;
    strt_q.delete(); done_q.delete();
    #1;
    check("rstmid_outs_now", 32'(outs()), 32'h0);
    step();
    rst = 1'b0;
    step();
    complete(12'h999);
    repeat (20) step();
    check("rstmid_no_strt", 32'(strt_q.size()), 32'd0);
    check("rstmid_no_cmplt", 32'(done_q.size()), 32'd0);
    check("rstmid_outs_after", 32'(outs()), 32'h0);

    // Randomized traffic against the reference model.
    do_reset();
    model_init();
    for (int i = 0; i < 3000; i++) begin
      bus.req0 = ($urandom_range(0, 3) == 0);
      bus.chnnl0 = 3'($urandom_range(0, 7));
      bus.req1 = ($urandom_range(0, 5) == 0);
      bus.chnnl1 = 3'($urandom_range(0, 7));
      bus.a2d_cnv_cmplt = m_conv ? (m_age == m_dly) : ($urandom_range(0, 9) == 0);
      bus.a2d_res = 12'($urandom);
      @(negedge clk);
      check($sformatf("rand_cyc%0d", i), 32'(outs()),
            32'(ov(m_strt, m_chn, m_d0, m_d1, m_res, m_err, m_conv)));
      @(posedge clk);
      model_step();
      #1;
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
